// File: rtl/rv32_dec_stage_pkg.sv
// Shared RV32 decode types: instruction/immediate aliases, immediate format
// enum, base opcode constants and the opcode classifier.
package rv32_dec_stage_pkg;

    localparam int RV32_XLEN = 32;

    typedef logic [31:0] rv32_instr_t;
    typedef logic [31:0] rv32_imm_t;

    typedef enum logic [2:0] {
        RV32_TYPE_I = 3'd0,
        RV32_TYPE_S = 3'd1,
        RV32_TYPE_B = 3'd2,
        RV32_TYPE_U = 3'd3,
        RV32_TYPE_J = 3'd4,
        RV32_TYPE_R = 3'd5
    } rv32_type_enum_t;

    localparam logic [6:0] RV32_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] RV32_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] RV32_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] RV32_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] RV32_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] RV32_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] RV32_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] RV32_OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] RV32_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] RV32_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] RV32_OPC_OP       = 7'b0110011;

    // One held pipeline entry: everything execute needs about an instruction.
    typedef struct packed {
        rv32_instr_t     instr;
        logic [31:0]     pc;
        rv32_imm_t       imm;
        rv32_type_enum_t imm_type;
        logic            illegal;
    } rv32_dec_entry_t;

    // Immediate format of a base opcode; unknown opcodes fall back to I.
    function automatic rv32_type_enum_t rv32_opc_to_type(input logic [6:0] opc);
        rv32_type_enum_t t;
        case (opc)
            RV32_OPC_LUI,
            RV32_OPC_AUIPC:    t = RV32_TYPE_U;
            RV32_OPC_JAL:      t = RV32_TYPE_J;
            RV32_OPC_JALR,
            RV32_OPC_LOAD,
            RV32_OPC_OP_IMM,
            RV32_OPC_MISC_MEM,
            RV32_OPC_SYSTEM:   t = RV32_TYPE_I;
            RV32_OPC_BRANCH:   t = RV32_TYPE_B;
            RV32_OPC_STORE:    t = RV32_TYPE_S;
            RV32_OPC_OP:       t = RV32_TYPE_R;
            default:           t = RV32_TYPE_I;
        endcase
        return t;
    endfunction

    // True for any opcode outside the recognised base set, which also covers
    // compressed encodings (opc[1:0] != 2'b11).
    function automatic logic rv32_opc_is_illegal(input logic [6:0] opc);
        logic ill;
        case (opc)
            RV32_OPC_LUI, RV32_OPC_AUIPC, RV32_OPC_JAL, RV32_OPC_JALR,
            RV32_OPC_LOAD, RV32_OPC_OP_IMM, RV32_OPC_MISC_MEM,
            RV32_OPC_SYSTEM, RV32_OPC_BRANCH, RV32_OPC_STORE,
            RV32_OPC_OP:       ill = 1'b0;
            default:           ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/rv32_dec_stage_imm_gen.sv
// RV32 immediate generator: assembles and sign-extends the immediate of an
// instruction for a given format. Opcode bits are not needed, so only
// instr[31:7] comes in.
module rv32_imm_gen
    import rv32_dec_stage_pkg::*;
(
    input  logic [31:7]     instr,
    input  rv32_type_enum_t imm_type,
    output rv32_imm_t       imm
);

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;

    // Gather the scattered immediate fields for each format.
    always_comb begin
        imm_i = instr[31:20];
        imm_s = {instr[31:25], instr[11:7]};
        imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    // Select and sign-extend by format; R has no immediate.
    always_comb begin
        imm = '0;
        case (imm_type)
            RV32_TYPE_I: imm = rv32_imm_t'(32'(imm_i));
            RV32_TYPE_S: imm = rv32_imm_t'(32'(imm_s));
            RV32_TYPE_B: imm = rv32_imm_t'(32'(imm_b));
            RV32_TYPE_U: imm = {instr[31:12], 12'h000};
            RV32_TYPE_J: imm = rv32_imm_t'(32'(imm_j));
            RV32_TYPE_R: imm = '0;
            default:     imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32_dec_stage.sv
// Decode pipeline stage: classifies each fetched instruction, computes its
// immediate at capture time and holds it in a main (head) register backed
// by one skid register, so in_ready depends only on registered state.
module rv32_dec_stage
    import rv32_dec_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  rv32_instr_t            in_instr,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output rv32_instr_t            out_instr,
    output logic [XLEN-1:0]        out_pc,
    output rv32_imm_t              out_imm,
    output rv32_type_enum_t        out_imm_type,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   main_valid_q, main_valid_d;
    logic                   skid_valid_q, skid_valid_d;
    rv32_dec_entry_t        main_q, main_d;
    rv32_dec_entry_t        skid_q, skid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    rv32_type_enum_t        in_type;
    logic                   in_illegal;
    rv32_imm_t              gen_imm;
    rv32_dec_entry_t        cap_entry;
    logic                   accept;
    logic                   pop;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    rv32_imm_gen u_imm_gen (
        .instr    (in_instr[31:7]),
        .imm_type (in_type),
        .imm      (gen_imm)
    );

    // Classify the incoming instruction and build the entry to capture.
    always_comb begin
        in_type                = rv32_opc_to_type(in_instr[6:0]);
        in_illegal             = rv32_opc_is_illegal(in_instr[6:0]);
        cap_entry.instr        = in_instr;
        cap_entry.pc           = in_pc;
        cap_entry.imm          = (in_type == RV32_TYPE_R) ? '0 : gen_imm;
        cap_entry.imm_type     = in_type;
        cap_entry.illegal      = in_illegal;
    end

    // Handshake terms; in_ready comes only from the skid occupancy flop.
    always_comb begin
        in_ready = !skid_valid_q;
        accept   = in_valid && in_ready;
        pop      = main_valid_q && out_ready;
    end

    // Next-state for main/skid occupancy and contents; flush wins outright.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_d       = cap_entry;
            end
        end else if (pop) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = cap_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = cap_entry;
            skid_valid_d = 1'b1;
        end
    end

    // Stall cycles: head waiting on execute; a flush cycle does not count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!flush && main_valid_q && !out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // State registers; reset clears occupancy, contents and the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // The head register drives execute directly.
    always_comb begin
        out_valid    = main_valid_q;
        out_instr    = main_q.instr;
        out_pc       = main_q.pc;
        out_imm      = main_q.imm;
        out_imm_type = main_q.imm_type;
        out_illegal  = main_q.illegal;
        stall_cnt    = stall_cnt_q;
    end

endmodule

// File: tb/tb_rv32_dec_stage.sv
// Testbench for rv32_dec_stage: directed vectors with hand-computed
// immediates, a scoreboard queue filled on accept and drained by a monitor.
module tb_rv32_dec_stage;
    import rv32_dec_stage_pkg::*;

    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    rv32_instr_t     in_instr;
    logic [31:0]     in_pc;
    logic            out_valid;
    logic            out_ready;
    rv32_instr_t     out_instr;
    logic [31:0]     out_pc;
    rv32_imm_t       out_imm;
    rv32_type_enum_t out_imm_type;
    logic            out_illegal;
    logic [SW-1:0]   stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } sb_t;

    sb_t sb[$];

    rv32_dec_stage #(.XLEN(32), .STALL_CNT_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type),
        .out_illegal  (out_illegal),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Hand-computed decode results: {known, imm, type, illegal}.
    function automatic logic [36:0] exp_of(input logic [31:0] instr);
        case (instr)
            32'hFFF00093: return {1'b1, 32'hFFFFFFFF, 3'd0, 1'b0}; // addi x1,x0,-1
            32'h12345037: return {1'b1, 32'h12345000, 3'd3, 1'b0}; // lui
            32'hFE000EE3: return {1'b1, 32'hFFFFFFFC, 3'd2, 1'b0}; // beq -4
            32'h0020A423: return {1'b1, 32'h00000008, 3'd1, 1'b0}; // sw x2,8(x1)
            32'h0080006F: return {1'b1, 32'h00000008, 3'd4, 1'b0}; // jal x0,8
            32'hABCDE097: return {1'b1, 32'hABCDE000, 3'd3, 1'b0}; // auipc
            32'h00000000: return {1'b1, 32'h00000000, 3'd0, 1'b1}; // all zero
            32'h002081B3: return {1'b1, 32'h00000000, 3'd5, 1'b0}; // add
            32'hFFF00091: return {1'b1, 32'hFFFFFFFF, 3'd0, 1'b1}; // low bits 01
            32'h0000007F: return {1'b1, 32'h00000000, 3'd0, 1'b1}; // opc 1111111
            32'h00500113: return {1'b1, 32'h00000005, 3'd0, 1'b0}; // addi 5
            32'h00700193: return {1'b1, 32'h00000007, 3'd0, 1'b0}; // addi 7
            32'h00900213: return {1'b1, 32'h00000009, 3'd0, 1'b0}; // addi 9
            32'h00100093: return {1'b1, 32'h00000001, 3'd0, 1'b0}; // addi 1
            default:      return '0;
        endcase
    endfunction

    // Monitor then acceptor, both sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", out_instr, 32'hxxxxxxxx);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("mon_instr", out_instr, e.instr);
                    check("mon_pc", out_pc, e.pc);
                    check("mon_imm", out_imm, e.imm);
                    check("mon_type", {29'd0, out_imm_type}, {29'd0, e.typ});
                    check("mon_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                logic [36:0] x;
                sb_t n;
                x = exp_of(in_instr);
                if (!x[36]) check("vector_known", in_instr, 32'hxxxxxxxx);
                n.instr = in_instr;
                n.pc    = in_pc;
                n.imm   = x[35:4];
                n.typ   = x[3:1];
                n.ill   = x[0];
                sb.push_back(n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seq[7];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0;
        seq = '{32'h00000000, 32'h002081B3, 32'hFFF00091, 32'h0000007F,
                32'h0020A423, 32'h0080006F, 32'hABCDE097};
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_imm", out_imm, 32'd0);
        check("rst_type", {29'd0, out_imm_type}, 32'd0);
        check("rst_illegal", {31'd0, out_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI -1, visible one cycle after acceptance
        out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        check("addi_valid", {31'd0, out_valid}, 32'd1);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        step();
        check("addi_drained", {31'd0, out_valid}, 32'd0);

        // LUI then BEQ back to back, no bubble
        in_valid = 1'b1; in_instr = 32'h12345037; in_pc = 32'h104;
        step();
        in_instr = 32'hFE000EE3; in_pc = 32'h108;
        check("lui_valid", {31'd0, out_valid}, 32'd1);
        check("lui_imm", out_imm, 32'h12345000);
        step();
        in_valid = 1'b0;
        check("beq_valid", {31'd0, out_valid}, 32'd1);
        check("beq_imm", out_imm, 32'hFFFFFFFC);
        check("beq_type", {29'd0, out_imm_type}, 32'd2);
        step();
        check("beq_drained", {31'd0, out_valid}, 32'd0);

        // Stall with A, B, C offered
        out_ready = 1'b0;
        check("stall_start", 32'(stall_cnt), 32'd0);
        in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h200;
        step();
        check("stallA_ready", {31'd0, in_ready}, 32'd1);
        check("stallA_head", out_instr, 32'h0020A423);
        in_instr = 32'h0080006F; in_pc = 32'h204;
        step();
        check("stallB_ready", {31'd0, in_ready}, 32'd0);
        check("stallB_cnt", 32'(stall_cnt), 32'd1);
        in_instr = 32'hABCDE097; in_pc = 32'h208;
        repeat (3) step();
        check("stall_cnt4", 32'(stall_cnt), 32'd4);
        check("stall_ready0", {31'd0, in_ready}, 32'd0);
        check("stall_head_held", out_instr, 32'h0020A423);
        check("stall_pc_held", out_pc, 32'h200);
        out_ready = 1'b1;
        step();
        check("rel_headB", out_instr, 32'h0080006F);
        check("rel_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("rel_headC", out_instr, 32'hABCDE097);
        step();
        check("rel_drained", {31'd0, out_valid}, 32'd0);
        check("rel_cnt", 32'(stall_cnt), 32'd4);

        // Flush with both entries held and a new input offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h300;
        step();
        in_instr = 32'h00700193; in_pc = 32'h304;
        step();
        check("fl_full", {31'd0, in_ready}, 32'd0);
        in_instr = 32'h00900213; in_pc = 32'h308;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready}, 32'd1);
        check("fl_cnt", 32'(stall_cnt), 32'd5);
        out_ready = 1'b1;
        repeat (3) step();
        check("fl_nodeliver", {31'd0, out_valid}, 32'd0);

        // Illegal, R-type and the other formats back to back
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_instr = seq[i]; in_pc = 32'h400 + 32'(i * 4);
            step();
            check("seq_head", out_instr, seq[i]);
        end
        in_valid = 1'b0;
        step();
        step();

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h500;
        step();
        in_instr = 32'h00500113; in_pc = 32'h504;
        step();
        in_valid = 1'b0;
        step();
        check("ar_cnt_before", 32'(stall_cnt), 32'd7);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_cnt", 32'(stall_cnt), 32'd0);
        check("ar_ready", {31'd0, in_ready}, 32'd1);
        check("ar_instr", out_instr, 32'd0);
        check("ar_type", {29'd0, out_imm_type}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h600;
        step();
        in_valid = 1'b0;
        check("ar_resume_valid", {31'd0, out_valid}, 32'd1);
        check("ar_resume_imm", out_imm, 32'h00000001);
        step();

        // Counter saturation
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00700193; in_pc = 32'h700;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("sat_cnt", 32'(stall_cnt), 32'(2**SW - 1));
        check("sat_head", out_instr, 32'h00700193);
        out_ready = 1'b1;
        step();
        check("sat_drained", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
